bcd_seg_scan: RTL and testbench



---
 rtl/bcd_seg_scan_if.sv | 25 ++
 rtl/bcd_seg_scan.sv | 112 +++++++++++
 tb/tb_bcd_seg_scan.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/bcd_seg_scan_if.sv
// Display-side bundle for bcd_seg_scan: BCD digit/dp inputs
// and the registered active-low segment, dp and anode drives.
interface bcd_seg_scan_if;
   logic [15:0] digits_in;
   logic [3:0]  dp_in;
   logic [6:0]  seg_n;
   logic        dp_n;
   logic [3:0]  an_n;

   modport master (
      output digits_in,
      output dp_in,
      input  seg_n,
      input  dp_n,
      input  an_n
   );

   modport slave (
      input  digits_in,
      input  dp_in,
      output seg_n,
      output dp_n,
      output an_n
   );
endinterface

// File: rtl/bcd_seg_scan.sv
// 4-digit multiplexed common-anode 7-segment driver, frame-latched inputs.
// Optional leading-zero blanking: define BCD_SEG_LZB_EN.
module bcd_seg_scan #(
   parameter int unsigned SCAN_DIV = 1000
) (
   input  logic          clk,
   input  logic          rst_n,
   bcd_seg_scan_if.slave bus
);

   localparam logic [15:0] LAST = 16'(SCAN_DIV - 1);

   logic [15:0] cnt_q, cnt_d;
   logic [1:0]  idx_q, idx_d;
   logic [15:0] sh_dig_q, sh_dig_d;
   logic [3:0]  sh_dp_q, sh_dp_d;
   logic [6:0]  seg_q, seg_d;
   logic        dp_q, dp_d;
   logic [3:0]  an_q, an_d;
   logic        wrap;
   logic [3:0]  nib;
   logic        blank;

   function automatic logic [6:0] decode(input logic [3:0] d);
      logic [6:0] s;
      case (d)
         4'd0:    s = 7'h40;
         4'd1:    s = 7'h79;
         4'd2:    s = 7'h24;
         4'd3:    s = 7'h30;
         4'd4:    s = 7'h19;
         4'd5:    s = 7'h12;
         4'd6:    s = 7'h02;
         4'd7:    s = 7'h78;
         4'd8:    s = 7'h00;
         4'd9:    s = 7'h10;
         default: s = 7'h3F;
      endcase
      return s;
   endfunction

   assign wrap = (cnt_q == LAST);

   // Select the shadow nibble for the digit currently being scanned
   always_comb begin
      nib = sh_dig_q[3:0];
      unique case (idx_q)
         2'd0: nib = sh_dig_q[3:0];
         2'd1: nib = sh_dig_q[7:4];
         2'd2: nib = sh_dig_q[11:8];
         2'd3: nib = sh_dig_q[15:12];
      endcase
   end

   // Leading-zero blank: this digit and every higher one are zero
   always_comb begin
      blank = 1'b0;
`ifdef BCD_SEG_LZB_EN
      unique case (idx_q)
         2'd0: blank = 1'b0;
         2'd1: blank = (sh_dig_q[15:4] == 12'd0);
         2'd2: blank = (sh_dig_q[15:8] == 8'd0);
         2'd3: blank = (sh_dig_q[15:12] == 4'd0);
      endcase
`endif
   end

   // Prescaler, scan index, frame capture and output next-state
   always_comb begin
      cnt_d    = cnt_q + 16'd1;
      idx_d    = idx_q;
      sh_dig_d = sh_dig_q;
      sh_dp_d  = sh_dp_q;
      if (wrap) begin
         cnt_d = 16'd0;
         idx_d = idx_q + 2'd1;
         if (idx_q == 2'd3) begin
            sh_dig_d = bus.digits_in;
            sh_dp_d  = bus.dp_in;
         end
      end
      an_d  = ~(4'b0001 << idx_q);
      seg_d = blank ? 7'h7F : decode(nib);
      dp_d  = ~sh_dp_q[idx_q];
   end

   // State and output registers, all forced off by async reset
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q    <= 16'd0;
         idx_q    <= 2'd0;
         sh_dig_q <= 16'd0;
         sh_dp_q  <= 4'd0;
         seg_q    <= 7'h7F;
         dp_q     <= 1'b1;
         an_q     <= 4'hF;
      end else begin
         cnt_q    <= cnt_d;
         idx_q    <= idx_d;
         sh_dig_q <= sh_dig_d;
         sh_dp_q  <= sh_dp_d;
         seg_q    <= seg_d;
         dp_q     <= dp_d;
         an_q     <= an_d;
      end
   end

   assign bus.seg_n = seg_q;
   assign bus.dp_n  = dp_q;
   assign bus.an_n  = an_q;

endmodule

// File: tb/tb_bcd_seg_scan.sv
// Scoreboard bench for bcd_seg_scan with SCAN_DIV=4.
// Expected display per cycle is queued by stimulus, checked by monitor.
module tb_bcd_seg_scan;

   typedef struct {
      int         cyc;
      logic [3:0] an;
      logic [6:0] seg;
      logic       dp;
   } exp_t;

   logic clk;
   logic rst_n;
   int   cyc;
   int   n_vec;
   int   n_fail;
   exp_t q[$];

   bcd_seg_scan_if bus ();

   bcd_seg_scan #(.SCAN_DIV(4)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

`ifdef BCD_SEG_LZB_EN
   localparam logic [6:0] Z3 = 7'h7F;
   localparam logic [6:0] Z2 = 7'h7F;
   localparam logic [6:0] Z1 = 7'h7F;
`else
   localparam logic [6:0] Z3 = 7'h40;
   localparam logic [6:0] Z2 = 7'h40;
   localparam logic [6:0] Z1 = 7'h40;
`endif

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Edges since last reset release; output after edge k sampled at cyc==k
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) cyc <= 0;
      else        cyc <= cyc + 1;
   end

   task automatic check(input string nm, input logic [3:0] an,
                        input logic [6:0] seg, input logic dp);
      n_vec++;
      if (bus.an_n !== an || bus.seg_n !== seg || bus.dp_n !== dp) begin
         n_fail++;
         $display("FAIL %s cyc=%0d got an=%h seg=%h dp=%b want an=%h seg=%h dp=%b",
                  nm, cyc, bus.an_n, bus.seg_n, bus.dp_n, an, seg, dp);
      end
   endtask

   // One frame starting at edge f0; s[i]/dp[i] are digit i expectations
   task automatic push_frame(input int f0, input logic [6:0] s0,
                             input logic [6:0] s1, input logic [6:0] s2,
                             input logic [6:0] s3, input logic [3:0] dp);
      logic [6:0] s [4];
      logic [3:0] one;
      exp_t e;
      s[0] = s0; s[1] = s1; s[2] = s2; s[3] = s3;
      for (int i = 0; i < 4; i++) begin
         one = 4'b0001 << i;
         for (int j = 0; j < 4; j++) begin
            e.cyc = f0 + 4 * i + j;
            e.an  = ~one;
            e.seg = s[i];
            e.dp  = ~dp[i];
            q.push_back(e);
         end
      end
   endtask

   // Monitor: compare every queued expectation at its cycle
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (rst_n) begin
            while (q.size() > 0 && q[0].cyc <= cyc) begin
               e = q.pop_front();
               if (e.cyc != cyc) begin
                  n_vec++;
                  n_fail++;
                  $display("FAIL sb_stale want_cyc=%0d got_cyc=%0d",
                           e.cyc, cyc);
               end else begin
                  check("scan", e.an, e.seg, e.dp);
               end
            end
         end
      end
   end

   initial begin
      n_vec  = 0;
      n_fail = 0;
      rst_n  = 1'b0;
      bus.digits_in = 16'h0000;
      bus.dp_in     = 4'h0;
      #23;
      check("reset_hold", 4'hF, 7'h7F, 1'b1);
      bus.digits_in = 16'h1234;
      #4 rst_n = 1'b1;
      push_frame(1, 7'h40, Z1, Z2, Z3, 4'h0);
      push_frame(17, 7'h19, 7'h30, 7'h24, 7'h79, 4'h0);
      push_frame(33, 7'h00, 7'h78, 7'h02, 7'h12, 4'h0);
      push_frame(49, 7'h10, 7'h3F, 7'h40, 7'h3F, 4'b0010);
`ifdef BCD_SEG_LZB_EN
      push_frame(65, 7'h40, 7'h12, 7'h7F, 7'h7F, 4'h0);
`else
      push_frame(65, 7'h40, 7'h12, 7'h40, 7'h40, 4'h0);
`endif
      while (cyc < 22) @(negedge clk);
      bus.digits_in = 16'h5678;
      while (cyc < 40) @(negedge clk);
      bus.digits_in = 16'hA0F9;
      bus.dp_in     = 4'b0010;
      while (cyc < 56) @(negedge clk);
      bus.digits_in = 16'h0050;
      bus.dp_in     = 4'h0;
      while (cyc < 90) @(negedge clk);
      check("pre_rst_B", 4'hB, Z2 == 7'h7F ? 7'h7F : 7'h40, 1'b1);
      #2 rst_n = 1'b0;
      #1 check("rst_async", 4'hF, 7'h7F, 1'b1);
      @(negedge clk);
      check("rst_held", 4'hF, 7'h7F, 1'b1);
      n_vec++;
      if (q.size() != 0) begin
         n_fail++;
         $display("FAIL sb_leftover got=%0d want=0", q.size());
         q.delete();
      end
      #2 rst_n = 1'b1;
      push_frame(1, 7'h40, Z1, Z2, Z3, 4'h0);
`ifdef BCD_SEG_LZB_EN
      push_frame(17, 7'h40, 7'h12, 7'h7F, 7'h7F, 4'h0);
`else
      push_frame(17, 7'h40, 7'h12, 7'h40, 7'h40, 4'h0);
`endif
      for (int k = 0; k < 60 && q.size() > 0; k++) @(negedge clk);
      @(negedge clk);
      n_vec++;
      if (q.size() != 0) begin
         n_fail++;
         $display("FAIL sb_timeout got=%0d want=0", q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
